pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It merges the load-use bubble request, a taken branch/jump resolved in Execute, a multi-cycle data-memory handshake in Memory, and a multi-cycle mul/div unit in Execute. From these it produces every pipeline-register write enable and flush. A small FSM holds the pipeline frozen across variable-latency memory and mul/div operations, with a memory timeout and a saturating stall-cycle performance counter.

---
 rtl/pipeline_stall_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. Merges the
// load-use bubble, taken branch/jump in Execute, the multi-cycle data-memory
// handshake in Memory and the multi-cycle mul/div unit in Execute into the
// pipeline-register write enables and flushes.
//
// Only the FSM state, the memory wait counter and the stall-cycle counter are
// registered. Every control output is a Mealy function of the current state
// and the inputs, so the pipeline reacts in the same cycle a hazard appears.
// MEM_TIMEOUT must be at least 2.
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             LoadUseHazard,
   input  logic             BranchTaken_E,
   input  logic             MemReq_M,
   input  logic             MemReady,
   input  logic             MulDivStart_E,
   input  logic             MulDivDone,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             ID_EX_Write,
   output logic             EX_MEM_Write,
   output logic             MEM_WB_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_Flush,
   output logic             MulDivGo,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCycles
);

   // Wait counter must be able to hold MEM_TIMEOUT-1 (the release point).
   localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_MD_BUSY  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WAIT_W-1:0]  r_wait_cnt;
   logic [WAIT_W-1:0]  w_wait_cnt_nxt;
   logic [CNT_W-1:0]   r_stall_cnt;

   logic               w_pc_write;
   logic               w_if_id_write;
   logic               w_id_ex_write;
   logic               w_ex_mem_write;
   logic               w_mem_wb_write;
   logic               w_if_id_flush;
   logic               w_id_ex_flush;
   logic               w_ex_mem_flush;
   logic               w_muldiv_go;
   logic               w_mem_timeout;
   logic               w_mem_miss;
   logic               w_wait_expired;

   // Saturating increment: the performance counter sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      if (value == CNT_MAX) begin
         return value;
      end else begin
         return value + CNT_W'(1);
      end
   endfunction

   assign w_mem_miss     = MemReq_M & ~MemReady;
   assign w_wait_expired = (r_wait_cnt == WAIT_LAST);

   // State register and memory wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= WAIT_ZERO;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   // Next-state logic: memory miss beats mul/div start; MEM_WAIT and MD_BUSY
   // only listen to their own completion signal.
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      case (r_state)
         ST_RUN: begin
            if (w_mem_miss) begin
               w_state_nxt    = ST_MEM_WAIT;
               w_wait_cnt_nxt = WAIT_ONE;
            end else if (MulDivStart_E) begin
               w_state_nxt    = ST_MD_BUSY;
               w_wait_cnt_nxt = WAIT_ZERO;
            end else begin
               w_state_nxt    = ST_RUN;
               w_wait_cnt_nxt = WAIT_ZERO;
            end
         end
         ST_MEM_WAIT: begin
            if (MemReady) begin
               w_state_nxt    = ST_RUN;
               w_wait_cnt_nxt = WAIT_ZERO;
            end else if (w_wait_expired) begin
               w_state_nxt    = ST_RUN;
               w_wait_cnt_nxt = WAIT_ZERO;
            end else begin
               w_state_nxt    = ST_MEM_WAIT;
               w_wait_cnt_nxt = r_wait_cnt + WAIT_ONE;
            end
         end
         ST_MD_BUSY: begin
            if (MulDivDone) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_MD_BUSY;
            end
            w_wait_cnt_nxt = WAIT_ZERO;
         end
         default: begin
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = WAIT_ZERO;
         end
      endcase
   end

   // Mealy output decode; everything is held inactive while reset is asserted.
   always_comb begin
      w_pc_write     = 1'b1;
      w_if_id_write  = 1'b1;
      w_id_ex_write  = 1'b1;
      w_ex_mem_write = 1'b1;
      w_mem_wb_write = 1'b1;
      w_if_id_flush  = 1'b0;
      w_id_ex_flush  = 1'b0;
      w_ex_mem_flush = 1'b0;
      w_muldiv_go    = 1'b0;
      w_mem_timeout  = 1'b0;
      if (!rst_n) begin
         w_pc_write     = 1'b0;
         w_if_id_write  = 1'b0;
         w_id_ex_write  = 1'b0;
         w_ex_mem_write = 1'b0;
         w_mem_wb_write = 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_mem_miss) begin
                  // Freeze the whole pipe until memory answers.
                  w_pc_write     = 1'b0;
                  w_if_id_write  = 1'b0;
                  w_id_ex_write  = 1'b0;
                  w_ex_mem_write = 1'b0;
                  w_mem_wb_write = 1'b0;
               end else if (MulDivStart_E) begin
                  // Hold front end, bubble into EX/MEM, kick the unit once.
                  w_pc_write     = 1'b0;
                  w_if_id_write  = 1'b0;
                  w_id_ex_write  = 1'b0;
                  w_ex_mem_flush = 1'b1;
                  w_muldiv_go    = 1'b1;
               end else if (BranchTaken_E) begin
                  // Squash the two wrong-path slots; PC loads the target.
                  // A simultaneous load-use belongs to the wrong path.
                  w_if_id_flush  = 1'b1;
                  w_id_ex_flush  = 1'b1;
               end else if (LoadUseHazard) begin
                  w_pc_write     = 1'b0;
                  w_if_id_write  = 1'b0;
                  w_id_ex_flush  = 1'b1;
               end else begin
                  w_pc_write     = 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               if (MemReady) begin
                  w_pc_write     = 1'b1;
               end else if (w_wait_expired) begin
                  w_mem_timeout  = 1'b1;
               end else begin
                  w_pc_write     = 1'b0;
                  w_if_id_write  = 1'b0;
                  w_id_ex_write  = 1'b0;
                  w_ex_mem_write = 1'b0;
                  w_mem_wb_write = 1'b0;
               end
            end
            ST_MD_BUSY: begin
               if (MulDivDone) begin
                  w_pc_write     = 1'b1;
               end else begin
                  // Older instructions in MEM/WB keep draining.
                  w_pc_write     = 1'b0;
                  w_if_id_write  = 1'b0;
                  w_id_ex_write  = 1'b0;
                  w_ex_mem_flush = 1'b1;
               end
            end
            default: begin
               w_pc_write     = 1'b1;
            end
         endcase
      end
   end

   // Stall-cycle performance counter: counts edges where the PC was held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= CNT_ZERO;
      end else if (!w_pc_write) begin
         r_stall_cnt <= sat_inc(r_stall_cnt);
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign PCWrite      = w_pc_write;
   assign IF_ID_Write  = w_if_id_write;
   assign ID_EX_Write  = w_id_ex_write;
   assign EX_MEM_Write = w_ex_mem_write;
   assign MEM_WB_Write = w_mem_wb_write;
   assign IF_ID_Flush  = w_if_id_flush;
   assign ID_EX_Flush  = w_id_ex_flush;
   assign EX_MEM_Flush = w_ex_mem_flush;
   assign MulDivGo     = w_muldiv_go;
   assign MemTimeout   = w_mem_timeout;
   assign StallCycles  = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_controller
// Directed table of per-cycle vectors (inputs, expected outputs, expected
// stall count after the edge) plus hand-written reset / mul-div / memory
// sequences. MEM_TIMEOUT=4, CNT_W=4 so timeout and saturation are reachable.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_controller;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 4;

   // Input encoding {ld, br, mreq, mrdy, mds, mdd}
   localparam logic [5:0] I_NONE = 6'b000000;
   localparam logic [5:0] I_LD   = 6'b100000;
   localparam logic [5:0] I_BR   = 6'b010000;
   localparam logic [5:0] I_MREQ = 6'b001000;
   localparam logic [5:0] I_MRDY = 6'b000100;
   localparam logic [5:0] I_MDS  = 6'b000010;
   localparam logic [5:0] I_MDD  = 6'b000001;

   // Output encoding {PC, IFID_W, IDEX_W, EXMEM_W, MEMWB_W,
   //                  IFID_F, IDEX_F, EXMEM_F, Go, Timeout}
   localparam logic [9:0] O_DEF = 10'b11111_000_00;
   localparam logic [9:0] O_FRZ = 10'b00000_000_00;
   localparam logic [9:0] O_LU  = 10'b00111_010_00;
   localparam logic [9:0] O_BR  = 10'b11111_110_00;
   localparam logic [9:0] O_MDS = 10'b00011_001_10;
   localparam logic [9:0] O_MDB = 10'b00011_001_00;
   localparam logic [9:0] O_TO  = 10'b11111_000_01;
   localparam logic [9:0] O_RST = 10'b00000_000_00;

   typedef struct packed {
      logic [5:0] in;
      logic [9:0] out;
      logic [3:0] cnt;
   } vec_t;

   localparam int NVEC = 29;

   logic clk = 1'b0;
   logic rst_n;
   logic ld, br, mreq, mrdy, mds, mdd;
   logic PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write;
   logic IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MulDivGo, MemTimeout;
   logic [CNT_W-1:0] StallCycles;
   logic [9:0] w_out;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vecs [NVEC];

   always #5 clk = ~clk;

   pipeline_stall_controller #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .LoadUseHazard (ld),
      .BranchTaken_E (br),
      .MemReq_M      (mreq),
      .MemReady      (mrdy),
      .MulDivStart_E (mds),
      .MulDivDone    (mdd),
      .PCWrite       (PCWrite),
      .IF_ID_Write   (IF_ID_Write),
      .ID_EX_Write   (ID_EX_Write),
      .EX_MEM_Write  (EX_MEM_Write),
      .MEM_WB_Write  (MEM_WB_Write),
      .IF_ID_Flush   (IF_ID_Flush),
      .ID_EX_Flush   (ID_EX_Flush),
      .EX_MEM_Flush  (EX_MEM_Flush),
      .MulDivGo      (MulDivGo),
      .MemTimeout    (MemTimeout),
      .StallCycles   (StallCycles)
   );

   assign w_out = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
                   IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MulDivGo, MemTimeout};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic apply(input logic [5:0] v);
      {ld, br, mreq, mrdy, mds, mdd} = v;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      apply(I_NONE);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int go_cnt, stall_seen, flush_seen, frz_seen;

      // Load-use, branch, memory wait, timeout, mul/div, saturation, priority.
      vecs[0]  = '{I_NONE,                       O_DEF, 4'd0};
      vecs[1]  = '{I_LD,                         O_LU,  4'd1};
      vecs[2]  = '{I_BR | I_LD,                  O_BR,  4'd1};
      vecs[3]  = '{I_NONE,                       O_DEF, 4'd1};
      vecs[4]  = '{I_MREQ,                       O_FRZ, 4'd2};
      vecs[5]  = '{I_LD | I_BR | I_MREQ | I_MDS, O_FRZ, 4'd3};
      vecs[6]  = '{I_MREQ,                       O_FRZ, 4'd4};
      vecs[7]  = '{I_MREQ | I_MRDY,              O_DEF, 4'd4};
      vecs[8]  = '{I_LD,                         O_LU,  4'd5};
      vecs[9]  = '{I_MREQ,                       O_FRZ, 4'd6};
      vecs[10] = '{I_MREQ,                       O_FRZ, 4'd7};
      vecs[11] = '{I_MREQ,                       O_FRZ, 4'd8};
      vecs[12] = '{I_MREQ,                       O_TO,  4'd8};
      vecs[13] = '{I_MREQ | I_MRDY,              O_DEF, 4'd8};
      vecs[14] = '{I_MDS,                        O_MDS, 4'd9};
      vecs[15] = '{I_MREQ,                       O_MDB, 4'd10};
      vecs[16] = '{I_NONE,                       O_MDB, 4'd11};
      vecs[17] = '{I_LD | I_BR | I_MDS,          O_MDB, 4'd12};
      vecs[18] = '{I_NONE,                       O_MDB, 4'd13};
      vecs[19] = '{I_NONE,                       O_MDB, 4'd14};
      vecs[20] = '{I_MDD,                        O_DEF, 4'd14};
      vecs[21] = '{I_MDD,                        O_DEF, 4'd14};
      vecs[22] = '{I_BR | I_MDS,                 O_MDS, 4'd15};
      vecs[23] = '{I_MDD,                        O_DEF, 4'd15};
      vecs[24] = '{I_LD,                         O_LU,  4'd15};
      vecs[25] = '{I_MREQ | I_MDS,               O_FRZ, 4'd15};
      vecs[26] = '{I_MRDY | I_MDS,               O_DEF, 4'd15};
      vecs[27] = '{I_MDS,                        O_MDS, 4'd15};
      vecs[28] = '{I_MDD,                        O_DEF, 4'd15};

      // Reset state: outputs held inactive even with requests present.
      rst_n = 1'b0;
      apply(I_LD | I_MREQ | I_MDS);
      #1;
      check("reset_outputs", 32'(w_out), 32'(O_RST));
      check("reset_count", 32'(StallCycles), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      apply(I_NONE);

      // Table-driven per-cycle vectors.
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         apply(vecs[i].in);
         #1;
         check($sformatf("vec%0d_out", i), 32'(w_out), 32'(vecs[i].out));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_cnt", i), 32'(StallCycles), 32'(vecs[i].cnt));
      end

      // Memory wait: three frozen cycles then release on ready, count 3.
      reset_dut();
      frz_seen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         apply(k == 3 ? (I_MREQ | I_MRDY) : I_MREQ);
         #1;
         if (w_out == O_FRZ) frz_seen++;
         if (k == 3) check("memwait_release_out", 32'(w_out), 32'(O_DEF));
         @(posedge clk);
      end
      #1;
      check("memwait_frozen_cycles", 32'(frz_seen), 32'd3);
      check("memwait_count", 32'(StallCycles), 32'd3);

      // Mul/div: start, five busy cycles, done -> one Go, six stalled cycles.
      reset_dut();
      go_cnt = 0; stall_seen = 0; flush_seen = 0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         apply(k == 0 ? I_MDS : (k == 6 ? I_MDD : I_NONE));
         #1;
         if (MulDivGo) go_cnt++;
         if (!PCWrite) stall_seen++;
         if (EX_MEM_Flush) flush_seen++;
         @(posedge clk);
      end
      #1;
      check("muldiv_go_pulses", 32'(go_cnt), 32'd1);
      check("muldiv_stall_cycles", 32'(stall_seen), 32'd6);
      check("muldiv_flush_cycles", 32'(flush_seen), 32'd6);
      check("muldiv_count", 32'(StallCycles), 32'd6);

      // Reset in the middle of MEM_WAIT: immediate quiet outputs, no timeout.
      reset_dut();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         apply(I_MREQ);
         @(posedge clk);
      end
      @(negedge clk);
      #1;
      check("midwait_frozen", 32'(w_out), 32'(O_FRZ));
      check("midwait_count_before", 32'(StallCycles), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("midwait_reset_out", 32'(w_out), 32'(O_RST));
      check("midwait_reset_count", 32'(StallCycles), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("reset_hold%0d", k), 32'(w_out), 32'(O_RST));
      end
      @(negedge clk);
      rst_n = 1'b1;
      apply(I_NONE);
      #1;
      check("post_reset_default", 32'(w_out), 32'(O_DEF));
      @(posedge clk);
      #1;
      check("post_reset_count", 32'(StallCycles), 32'd0);
      @(negedge clk);
      apply(I_LD);
      #1;
      check("post_reset_loaduse", 32'(w_out), 32'(O_LU));
      @(posedge clk);
      #1;
      check("post_reset_lu_count", 32'(StallCycles), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         apply(I_NONE);
         #1;
         check($sformatf("post_reset_idle%0d", k), 32'(w_out), 32'(O_DEF));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
